// File: rtl/uio_bot_bank_arbiter.sv
// uio_bot_bank_arbiter: shares the bottom user-IO bank between NREQ requesters.
// Round-robin arbitration with dead-cycle turnaround on every ownership change.
// Pad inputs are read back through a capture register.
//
// Ports:
//   CLK, resetn             clock, asynchronous active-low reset
//   req[NREQ]               per-requester bank request (level)
//   req_data/req_oe         per-requester data/enables, slice i = [i*WIDTH +: WIDTH]
//   gnt[NREQ], owner[3]     one-hot grant, granted index (valid while busy_grant)
//   busy_grant              high in GRANT state
//   uio_fin/uio_oe[WIDTH]   pad data/enables toward UIO_BOT_FIN
//   uio_fout[WIDTH]         pad inputs from UIO_BOT_FOUT
//   rd_data/rd_valid        registered pad read-back and its grant qualifier
//
// Build option: define UIO_BOT_ARB_SYNC_EN to pass uio_fout through a 2-flop
// synchronizer before capture (read-back latency 3 cycles instead of 1).
module uio_bot_bank_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned MAX_HOLD    = 64
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*WIDTH-1:0]   req_oe,
  output logic [NREQ-1:0]         gnt,
  output logic [2:0]              owner,
  output logic                    busy_grant,
  output logic [WIDTH-1:0]        uio_fin,
  output logic [WIDTH-1:0]        uio_oe,
  input  logic [WIDTH-1:0]        uio_fout,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid
);

  localparam int unsigned HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [3:0]        DEAD_LOAD = (DEAD_CYCLES == 0) ? 4'd1 : 4'(DEAD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [2:0]        LAST_REQ  = 3'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, TURN_ON, GRANT, TURN_OFF} state_t;

  state_t              state, state_nxt;
  logic [2:0]          owner_nxt;
  logic [2:0]          rr_ptr, rr_nxt;
  logic [3:0]          dead_cnt, dead_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [7:0]          req_pad;
  logic [3:0]          idx;
  logic [2:0]          pick;
  logic                pick_vld;
  logic                others;
  logic [NREQ-1:0]     gnt_nxt;
  logic [WIDTH-1:0]    fin_nxt, oe_nxt;
  logic                busy_nxt, vld_nxt;

  // Zero-padded request vector so a 3-bit owner index always selects in range.
  assign req_pad = 8'(req);
  assign others  = |(req_pad & ~(8'd1 << owner));

  // Round-robin pick: first set request at or after rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 4'(rr_ptr) + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!pick_vld && req_pad[idx[2:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[2:0];
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      dead_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      dead_cnt <= dead_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    dead_nxt  = dead_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick;
          if (DEAD_CYCLES == 0) begin
            state_nxt = GRANT;
            hold_nxt  = HOLD_ONE;
          end else begin
            state_nxt = TURN_ON;
            dead_nxt  = DEAD_LOAD;
          end
        end
      end
      TURN_ON: begin
        if (!req_pad[owner]) begin
          state_nxt = TURN_OFF;
          dead_nxt  = DEAD_LOAD;
        end else if (dead_cnt <= 4'd1) begin
          state_nxt = GRANT;
          dead_nxt  = '0;
          hold_nxt  = HOLD_ONE;
        end else begin
          dead_nxt = dead_cnt - 4'd1;
        end
      end
      GRANT: begin
        // hold_cnt numbers the current GRANT cycle (1..MAX_HOLD).
        if (!req_pad[owner] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && others)) begin
          state_nxt = TURN_OFF;
          dead_nxt  = DEAD_LOAD;
          hold_nxt  = '0;
        end else if (MAX_HOLD != 0) begin
          hold_nxt = (hold_cnt == HOLD_MAX) ? HOLD_ONE : hold_cnt + HOLD_ONE;
        end
      end
      TURN_OFF: begin
        if (dead_cnt <= 4'd1) begin
          state_nxt = IDLE;
          dead_nxt  = '0;
          rr_nxt    = (owner == LAST_REQ) ? 3'd0 : owner + 3'd1;
        end else begin
          dead_nxt = dead_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: values loaded into the output registers, aligned with state_nxt.
  always_comb begin
    gnt_nxt  = '0;
    fin_nxt  = '0;
    oe_nxt   = '0;
    busy_nxt = (state_nxt == GRANT);
    vld_nxt  = (state == GRANT) && (state_nxt == GRANT);
    if (state_nxt == GRANT) begin
      gnt_nxt = NREQ'(8'd1 << owner_nxt);
      for (int i = 0; i < NREQ; i++) begin
        if (int'(owner_nxt) == i) begin
          fin_nxt = req_data[i*WIDTH +: WIDTH];
          oe_nxt  = req_oe[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef UIO_BOT_ARB_SYNC_EN
  logic [WIDTH-1:0] sync_q0, sync_q1;
  logic [1:0]       vld_q;
  logic             vld_clr;

  // Pending valids are dropped when the grant ends.
  assign vld_clr = (state != TURN_OFF) && (state_nxt == TURN_OFF);
`endif

  // Output registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      gnt        <= '0;
      busy_grant <= 1'b0;
      uio_fin    <= '0;
      uio_oe     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
`ifdef UIO_BOT_ARB_SYNC_EN
      sync_q0    <= '0;
      sync_q1    <= '0;
      vld_q      <= '0;
`endif
    end else begin
      gnt        <= gnt_nxt;
      busy_grant <= busy_nxt;
      uio_fin    <= fin_nxt;
      uio_oe     <= oe_nxt;
`ifdef UIO_BOT_ARB_SYNC_EN
      sync_q0    <= uio_fout;
      sync_q1    <= sync_q0;
      rd_data    <= sync_q1;
      vld_q[0]   <= vld_nxt;
      vld_q[1]   <= vld_q[0] & ~vld_clr;
      rd_valid   <= vld_q[1] & ~vld_clr;
`else
      rd_data    <= uio_fout;
      rd_valid   <= vld_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uio_bot_bank_arbiter.sv
// Directed testbench for uio_bot_bank_arbiter (default parameters).
module tb_uio_bot_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 20;

  logic                  CLK;
  logic                  resetn;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*WIDTH-1:0] req_oe;
  logic [NREQ-1:0]       gnt;
  logic [2:0]            owner;
  logic                  busy_grant;
  logic [WIDTH-1:0]      uio_fin;
  logic [WIDTH-1:0]      uio_oe;
  logic [WIDTH-1:0]      uio_fout;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  uio_bot_bank_arbiter dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .req        (req),
    .req_data   (req_data),
    .req_oe     (req_oe),
    .gnt        (gnt),
    .owner      (owner),
    .busy_grant (busy_grant),
    .uio_fin    (uio_fin),
    .uio_oe     (uio_oe),
    .uio_fout   (uio_fout),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) until gnt becomes non-zero.
  task automatic wait_gnt(input int limit);
    int n;
    n = 0;
    while (gnt == '0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int ok;
    logic [WIDTH-1:0] oe_acc;

    resetn   = 1'b0;
    req      = 4'b0011;
    req_data = '0;
    req_oe   = '0;
    uio_fout = '0;
    req_data[0 +: WIDTH] = 20'hABCDE;
    req_oe[0 +: WIDTH]   = 20'hFFFFF;

    // Reset held with requests pending: everything stays at zero.
    repeat (3) tick();
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy",  32'(busy_grant), 32'h0);
    check("rst_fin",   32'(uio_fin), 32'h0);
    check("rst_oe",    32'(uio_oe), 32'h0);
    check("rst_rdv",   32'(rd_valid), 32'h0);

    // Release: IDLE (cycle 1), TURN_ON x2, then GRANT in cycle 4.
    resetn = 1'b1;
    check("c1_oe", 32'(uio_oe), 32'h0);
    tick();
    check("c2_oe",  32'(uio_oe), 32'h0);
    check("c2_gnt", 32'(gnt), 32'h0);
    tick();
    check("c3_oe",  32'(uio_oe), 32'h0);
    check("c3_gnt", 32'(gnt), 32'h0);
    tick();
    check("c4_gnt",   32'(gnt), 32'h1);
    check("c4_busy",  32'(busy_grant), 32'h1);
    check("c4_owner", 32'(owner), 32'h0);
    check("c4_fin",   32'(uio_fin), 32'hABCDE);
    check("c4_oe",    32'(uio_oe), 32'hFFFFF);
    check("c4_rdv",   32'(rd_valid), 32'h0);

    // Pass-through with one-cycle latency.
    tick();
    check("g2_rdv", 32'(rd_valid), 32'h1);
    req_data[0 +: WIDTH] = 20'h13579;
    check("fin_old", 32'(uio_fin), 32'hABCDE);
    tick();
    check("fin_new", 32'(uio_fin), 32'h13579);
    req_oe[0 +: WIDTH] = 20'h000FF;
    tick();
    check("oe_new", 32'(uio_oe), 32'h000FF);

    // Asynchronous reset mid-cycle in GRANT.
    #2;
    resetn = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt), 32'h0);
    check("arst_busy", 32'(busy_grant), 32'h0);
    check("arst_oe",   32'(uio_oe), 32'h0);
    check("arst_fin",  32'(uio_fin), 32'h0);
    check("arst_rdv",  32'(rd_valid), 32'h0);

    // req0 and req2 contend: gnt0 for exactly 64 cycles, 5-cycle oe=0 gap, then req2.
    req = 4'b0101;
    req_data[0 +: WIDTH]         = 20'hABCDE;
    req_oe[0 +: WIDTH]           = 20'hFFFFF;
    req_data[2*WIDTH +: WIDTH]   = 20'h2468A;
    req_oe[2*WIDTH +: WIDTH]     = 20'h0F0F0;
    tick();
    resetn = 1'b1;
    wait_gnt(10);
    check("mh_first", 32'(gnt), 32'h1);
    n = 0;
    while (gnt == 4'b0001 && n < 200) begin
      n++;
      tick();
    end
    check("mh_len", 32'(n), 32'd64);
    n = 0;
    oe_acc = '0;
    while (gnt == '0 && n < 50) begin
      oe_acc = oe_acc | uio_oe;
      n++;
      tick();
    end
    check("gap_len", 32'(n), 32'd5);
    check("gap_oe",  32'(oe_acc), 32'h0);
    check("mh_next", 32'(gnt), 32'h4);
    check("mh_own",  32'(owner), 32'h2);
    check("mh_oe",   32'(uio_oe), 32'h0F0F0);
    check("mh_fin",  32'(uio_fin), 32'h2468A);

    // Release everything and let the FSM settle in IDLE (rr_ptr = 3).
    req = '0;
    repeat (8) tick();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_oe",  32'(uio_oe), 32'h0);

    // req1 alone: grant persists well past MAX_HOLD, oe never drops.
    req = 4'b0010;
    req_data[1*WIDTH +: WIDTH] = 20'h11111;
    req_oe[1*WIDTH +: WIDTH]   = 20'hFFFFF;
    wait_gnt(10);
    check("solo_gnt", 32'(gnt), 32'h2);
    ok = 0;
    for (int c = 0; c < 150; c++) begin
      if (gnt == 4'b0010 && uio_oe == 20'hFFFFF && busy_grant) ok++;
      tick();
    end
    check("solo_hold", 32'(ok), 32'd150);

    // Read-back during GRANT.
    uio_fout = 20'h5A5A5;
`ifdef UIO_BOT_ARB_SYNC_EN
    repeat (2) tick();
`endif
    tick();
    check("rd_data",  32'(rd_data), 32'h5A5A5);
    check("rd_valid", 32'(rd_valid), 32'h1);

    // Owner drops: first TURN_OFF cycle clears grant, pads and rd_valid.
    req = '0;
    tick();
    check("off_gnt",  32'(gnt), 32'h0);
    check("off_busy", 32'(busy_grant), 32'h0);
    check("off_oe",   32'(uio_oe), 32'h0);
    check("off_fin",  32'(uio_fin), 32'h0);
    check("off_rdv",  32'(rd_valid), 32'h0);

    // One-cycle req3 pulse: selected in IDLE, dropped in TURN_ON, never granted.
    repeat (6) tick();
    req = 4'b1000;
    tick();
    req = '0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (gnt != '0) n++;
      tick();
    end
    check("pulse_nognt", 32'(n), 32'd0);

    // rr_ptr wrapped 3 -> 0, so req1 wins over req2.
    req = 4'b0110;
    wait_gnt(10);
    check("wrap_gnt", 32'(gnt), 32'h2);
    check("wrap_own", 32'(owner), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
